// File: rtl/cache_req_arbiter_pkg.sv
// Shared memory-interface types for the front-end requesters and the cache arbiter.
// Holds the owner encoding (also used by debug/perf logic), field widths and error codes.
// Optional feature macro used by the arbiter: CACHE_ARB_RR_EN (round-robin tie break).
package meminf;

  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} ArbOwner;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MASK_W  = 4;
  localparam int ERRTY_W = 2;

  localparam logic [ERRTY_W-1:0] ERR_NONE        = 2'd0;
  localparam logic [ERRTY_W-1:0] FE_ACCESS_FAULT = 2'd1;
  localparam logic [ERRTY_W-1:0] FE_PAGE_FAULT   = 2'd2;
  localparam logic [ERRTY_W-1:0] FE_MISALIGNED   = 2'd3;

  // Saturating 4-bit increment used by the anti-starvation counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/cache_req_arbiter_grant.sv
// Grant policy for the cache arbiter: combinational pick plus its small amount of history.
// Default: data priority, instruction wins once after STARVE_LIMIT consecutive lost ties.
// CACHE_ARB_RR_EN: ties go to whoever did not win the previous grant; no counter exists.
module cache_arb_grant
  import meminf::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  input  logic d_valid,
  input  logic take,
  input  logic idle,
  output logic grant_i,
  output logic grant_d
);

`ifdef CACHE_ARB_RR_EN

  ArbOwner prev_win;

  // Tie goes to the requester that lost the previous grant.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_valid && d_valid) begin
      if (prev_win == OWN_D) grant_i = 1'b1;
      else                   grant_d = 1'b1;
    end else begin
      grant_i = i_valid;
      grant_d = d_valid;
    end
  end

  // Remember the winner of every accepted grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     prev_win <= OWN_D;
    else if (take) prev_win <= grant_i ? OWN_I : OWN_D;
  end

`else

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == LIMIT);

  // Data wins ties unless instruction has lost LIMIT ties in a row.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_valid && d_valid) begin
      if (starved) grant_i = 1'b1;
      else         grant_d = 1'b1;
    end else begin
      grant_i = i_valid;
      grant_d = d_valid;
    end
  end

  // Count ties lost by instruction; any instruction win or idle gap without it resets the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           starve_cnt <= 4'd0;
    else if (take && grant_i)            starve_cnt <= 4'd0;
    else if (idle && !i_valid)           starve_cnt <= 4'd0;
    else if (take && grant_d && i_valid) starve_cnt <= sat_inc(starve_cnt, LIMIT);
  end

`endif

endmodule

// File: rtl/cache_req_arbiter.sv
// Shares one cache request/response port between instruction fetch and data; one transaction in flight.
// Latency: accept at T, memreq valid from T+1, response routed combinationally in the memresp cycle.
// Backpressure: losers and all requesters outside IDLE see ready=0 and must hold; memreq stalls hold fields.
// Optional: CACHE_ARB_RR_EN selects round-robin tie break instead of data priority with anti-starvation.
module cache_req_arbiter
  import meminf::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ireq_valid,
  output logic               ireq_ready,
  input  logic [ADDR_W-1:0]  ireq_addr,
  input  logic               ireq_wen,
  input  logic [DATA_W-1:0]  ireq_wdata,
  input  logic [MASK_W-1:0]  ireq_wmask,
  input  logic               ireq_pte,
  output logic               iresp_valid,
  output logic [DATA_W-1:0]  iresp_rdata,
  output logic               iresp_error,
  output logic [ERRTY_W-1:0] iresp_errty,
  input  logic               dreq_valid,
  output logic               dreq_ready,
  input  logic [ADDR_W-1:0]  dreq_addr,
  input  logic               dreq_wen,
  input  logic [DATA_W-1:0]  dreq_wdata,
  input  logic [MASK_W-1:0]  dreq_wmask,
  input  logic               dreq_pte,
  output logic               dresp_valid,
  output logic [DATA_W-1:0]  dresp_rdata,
  output logic               dresp_error,
  output logic [ERRTY_W-1:0] dresp_errty,
  output logic               memreq_valid,
  input  logic               memreq_ready,
  output logic [ADDR_W-1:0]  memreq_addr,
  output logic               memreq_wen,
  output logic [DATA_W-1:0]  memreq_wdata,
  output logic [MASK_W-1:0]  memreq_wmask,
  output logic               memreq_pte,
  input  logic               memresp_valid,
  input  logic [DATA_W-1:0]  memresp_rdata,
  input  logic               memresp_error,
  input  logic [ERRTY_W-1:0] memresp_errty
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} statetype;

  statetype state;
  ArbOwner  owner;
  logic     grant_i, grant_d;
  logic     idle, take, route;

  // Readies are suppressed while reset is held even though the state already reads IDLE.
  assign idle       = (state == IDLE) && !reset;
  assign take       = idle && (grant_i || grant_d);
  assign ireq_ready = idle && grant_i;
  assign dreq_ready = idle && grant_d;

  cache_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .clk     (clk),
    .reset   (reset),
    .i_valid (ireq_valid),
    .d_valid (dreq_valid),
    .take    (take),
    .idle    (idle),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  // Transaction FSM; the saved request registers drive memreq directly so it stays stable under stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= OWN_D;
      memreq_valid <= 1'b0;
      memreq_addr  <= '0;
      memreq_wen   <= 1'b0;
      memreq_wdata <= '0;
      memreq_wmask <= '0;
      memreq_pte   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            owner        <= grant_i ? OWN_I : OWN_D;
            memreq_valid <= 1'b1;
            memreq_addr  <= grant_i ? ireq_addr  : dreq_addr;
            memreq_wen   <= grant_i ? ireq_wen   : dreq_wen;
            memreq_wdata <= grant_i ? ireq_wdata : dreq_wdata;
            memreq_wmask <= grant_i ? ireq_wmask : dreq_wmask;
            memreq_pte   <= grant_i ? ireq_pte   : dreq_pte;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (memreq_ready) begin
            memreq_valid <= 1'b0;
            state        <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (memresp_valid) state <= IDLE;
        end
        default: begin
          memreq_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Response only counts in WAIT_RESP; anything arriving elsewhere (e.g. after a reset) is dropped.
  assign route = (state == WAIT_RESP) && memresp_valid;

  // Pass the response through to the owner only; the other side stays all-zero.
  always_comb begin
    iresp_valid = route && (owner == OWN_I);
    dresp_valid = route && (owner == OWN_D);
    iresp_rdata = iresp_valid ? memresp_rdata : '0;
    iresp_error = iresp_valid ? memresp_error : 1'b0;
    iresp_errty = iresp_valid ? memresp_errty : '0;
    dresp_rdata = dresp_valid ? memresp_rdata : '0;
    dresp_error = dresp_valid ? memresp_error : 1'b0;
    dresp_errty = dresp_valid ? memresp_errty : '0;
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: single request, tie arbitration order, stall, error, mid-flight reset.
// Inputs change 1 time unit after posedge; outputs are checked 3 units later, before the next edge.
// Expected tie order depends on CACHE_ARB_RR_EN.
module tb_cache_req_arbiter;
  import meminf::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid, ireq_ready, ireq_wen, ireq_pte;
  logic [31:0] ireq_addr, ireq_wdata;
  logic [3:0]  ireq_wmask;
  logic        iresp_valid, iresp_error;
  logic [31:0] iresp_rdata;
  logic [1:0]  iresp_errty;
  logic        dreq_valid, dreq_ready, dreq_wen, dreq_pte;
  logic [31:0] dreq_addr, dreq_wdata;
  logic [3:0]  dreq_wmask;
  logic        dresp_valid, dresp_error;
  logic [31:0] dresp_rdata;
  logic [1:0]  dresp_errty;
  logic        memreq_valid, memreq_ready, memreq_wen, memreq_pte;
  logic [31:0] memreq_addr, memreq_wdata;
  logic [3:0]  memreq_wmask;
  logic        memresp_valid, memresp_error;
  logic [31:0] memresp_rdata;
  logic [1:0]  memresp_errty;

  int errors = 0;
  int checks = 0;
  logic exp_i [10];

  cache_req_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_ready(ireq_ready), .ireq_addr(ireq_addr), .ireq_wen(ireq_wen),
    .ireq_wdata(ireq_wdata), .ireq_wmask(ireq_wmask), .ireq_pte(ireq_pte),
    .iresp_valid(iresp_valid), .iresp_rdata(iresp_rdata), .iresp_error(iresp_error), .iresp_errty(iresp_errty),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr), .dreq_wen(dreq_wen),
    .dreq_wdata(dreq_wdata), .dreq_wmask(dreq_wmask), .dreq_pte(dreq_pte),
    .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata), .dresp_error(dresp_error), .dresp_errty(dresp_errty),
    .memreq_valid(memreq_valid), .memreq_ready(memreq_ready), .memreq_addr(memreq_addr), .memreq_wen(memreq_wen),
    .memreq_wdata(memreq_wdata), .memreq_wmask(memreq_wmask), .memreq_pte(memreq_pte),
    .memresp_valid(memresp_valid), .memresp_rdata(memresp_rdata), .memresp_error(memresp_error),
    .memresp_errty(memresp_errty)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef CACHE_ARB_RR_EN
    for (int g = 0; g < 10; g++) exp_i[g] = ((g % 2) == 0);
`else
    for (int g = 0; g < 10; g++) exp_i[g] = (g == 4) || (g == 9);
`endif
    reset = 1'b1;
    ireq_valid = 1'b1; ireq_addr = 32'h0; ireq_wen = 1'b0; ireq_wdata = 32'h0; ireq_wmask = 4'h0; ireq_pte = 1'b0;
    dreq_valid = 1'b1; dreq_addr = 32'h0; dreq_wen = 1'b0; dreq_wdata = 32'h0; dreq_wmask = 4'h0; dreq_pte = 1'b0;
    memreq_ready = 1'b0; memresp_valid = 1'b0; memresp_rdata = 32'h0; memresp_error = 1'b0; memresp_errty = 2'd0;

    // Reset state: everything low even with both requesters valid.
    #3;
    chk("rst_memreq_valid", {31'b0, memreq_valid}, 32'd0);
    chk("rst_ireq_ready", {31'b0, ireq_ready}, 32'd0);
    chk("rst_dreq_ready", {31'b0, dreq_ready}, 32'd0);
    chk("rst_resp_valid", {30'b0, iresp_valid, dresp_valid}, 32'd0);
    tick; tick;
    reset = 1'b0;

    // 1: lone data load at 0x100.
    ireq_valid = 1'b0; dreq_valid = 1'b1; dreq_addr = 32'h100; dreq_wen = 1'b0;
    #3;
    chk("t1_dreq_ready", {31'b0, dreq_ready}, 32'd1);
    chk("t1_ireq_ready", {31'b0, ireq_ready}, 32'd0);
    tick;
    dreq_valid = 1'b0; memreq_ready = 1'b1;
    #3;
    chk("t1_memreq_valid", {31'b0, memreq_valid}, 32'd1);
    chk("t1_memreq_addr", memreq_addr, 32'h100);
    chk("t1_memreq_wen", {31'b0, memreq_wen}, 32'd0);
    tick;
    memreq_ready = 1'b0;
    #3;
    chk("t1_wait_memreq_valid", {31'b0, memreq_valid}, 32'd0);
    chk("t1_wait_dresp_valid", {31'b0, dresp_valid}, 32'd0);
    tick;
    memresp_valid = 1'b1; memresp_rdata = 32'hdeadbeef;
    #3;
    chk("t1_dresp_valid", {31'b0, dresp_valid}, 32'd1);
    chk("t1_dresp_rdata", dresp_rdata, 32'hdeadbeef);
    chk("t1_iresp_valid", {31'b0, iresp_valid}, 32'd0);
    tick;
    memresp_valid = 1'b0;
    #3;
    chk("t1_dresp_once", {31'b0, dresp_valid}, 32'd0);

    // 2/3: both requesters valid continuously, ten grants.
    ireq_valid = 1'b1; ireq_addr = 32'h2000;
    dreq_valid = 1'b1; dreq_addr = 32'h3000;
    for (int g = 0; g < 10; g++) begin
      #3;
      chk($sformatf("t2_ireq_ready_%0d", g), {31'b0, ireq_ready}, {31'b0, exp_i[g]});
      chk($sformatf("t2_dreq_ready_%0d", g), {31'b0, dreq_ready}, {31'b0, !exp_i[g]});
      tick;
      memreq_ready = 1'b1;
      #3;
      chk($sformatf("t2_addr_%0d", g), memreq_addr, exp_i[g] ? 32'h2000 : 32'h3000);
      tick;
      memreq_ready = 1'b0; memresp_valid = 1'b1; memresp_rdata = 32'(g);
      #3;
      chk($sformatf("t2_iresp_%0d", g), {31'b0, iresp_valid}, {31'b0, exp_i[g]});
      chk($sformatf("t2_dresp_%0d", g), {31'b0, dresp_valid}, {31'b0, !exp_i[g]});
      tick;
      memresp_valid = 1'b0;
    end

    // 4: data store stalled five cycles in ISSUE; inputs change after acceptance.
    ireq_valid = 1'b0;
    dreq_valid = 1'b1; dreq_addr = 32'h400; dreq_wen = 1'b1; dreq_wdata = 32'h12345678; dreq_wmask = 4'hf;
    #3;
    chk("t4_dreq_ready", {31'b0, dreq_ready}, 32'd1);
    tick;
    dreq_valid = 1'b0; dreq_addr = 32'hbad; dreq_wen = 1'b0; dreq_wdata = 32'h0;
    ireq_valid = 1'b1; ireq_addr = 32'h800;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk($sformatf("t4_valid_%0d", k), {31'b0, memreq_valid}, 32'd1);
      chk($sformatf("t4_addr_%0d", k), memreq_addr, 32'h400);
      chk($sformatf("t4_wdata_%0d", k), memreq_wdata, 32'h12345678);
      chk($sformatf("t4_wen_%0d", k), {31'b0, memreq_wen}, 32'd1);
      chk($sformatf("t4_no_grant_%0d", k), {30'b0, ireq_ready, dreq_ready}, 32'd0);
      tick;
    end
    memreq_ready = 1'b1;
    #3;
    chk("t4_hold_addr", memreq_addr, 32'h400);
    tick;
    memreq_ready = 1'b0; memresp_valid = 1'b1; memresp_rdata = 32'h55;
    #3;
    chk("t4_dresp_valid", {31'b0, dresp_valid}, 32'd1);
    tick;
    memresp_valid = 1'b0;

    // 5: instruction fetch that returns an access fault.
    #3;
    chk("t5_ireq_ready", {31'b0, ireq_ready}, 32'd1);
    tick;
    ireq_valid = 1'b0; memreq_ready = 1'b1;
    #3;
    chk("t5_memreq_addr", memreq_addr, 32'h800);
    tick;
    memreq_ready = 1'b0; memresp_valid = 1'b1; memresp_rdata = 32'h0;
    memresp_error = 1'b1; memresp_errty = FE_ACCESS_FAULT;
    #3;
    chk("t5_iresp_valid", {31'b0, iresp_valid}, 32'd1);
    chk("t5_iresp_error", {31'b0, iresp_error}, 32'd1);
    chk("t5_iresp_errty", {30'b0, iresp_errty}, {30'b0, FE_ACCESS_FAULT});
    chk("t5_dresp_valid", {31'b0, dresp_valid}, 32'd0);
    tick;
    memresp_valid = 1'b0; memresp_error = 1'b0; memresp_errty = 2'd0;
    dreq_valid = 1'b1; dreq_addr = 32'h500; dreq_wen = 1'b0;
    #3;
    chk("t5_back_idle", {31'b0, dreq_ready}, 32'd1);

    // 6: reset during WAIT_RESP, stale response after release.
    tick;
    dreq_valid = 1'b0; memreq_ready = 1'b1;
    #3;
    chk("t6_memreq_addr", memreq_addr, 32'h500);
    tick;
    memreq_ready = 1'b0;
    reset = 1'b1; dreq_valid = 1'b1; dreq_addr = 32'h600;
    #3;
    chk("t6_rst_memreq_valid", {31'b0, memreq_valid}, 32'd0);
    chk("t6_rst_ready", {30'b0, ireq_ready, dreq_ready}, 32'd0);
    chk("t6_rst_resp", {30'b0, iresp_valid, dresp_valid}, 32'd0);
    tick;
    #3;
    chk("t6_rst_hold_ready", {31'b0, dreq_ready}, 32'd0);
    tick;
    reset = 1'b0; dreq_valid = 1'b0;
    #3;
    chk("t6_rel_memreq_valid", {31'b0, memreq_valid}, 32'd0);
    tick;
    memresp_valid = 1'b1; memresp_rdata = 32'h0badbad0;
    #3;
    chk("t6_stale_dresp", {31'b0, dresp_valid}, 32'd0);
    chk("t6_stale_iresp", {31'b0, iresp_valid}, 32'd0);
    tick;
    memresp_valid = 1'b0; dreq_valid = 1'b1;
    #3;
    chk("t6_next_ready", {31'b0, dreq_ready}, 32'd1);
    tick;
    dreq_valid = 1'b0; memreq_ready = 1'b1;
    #3;
    chk("t6_next_valid", {31'b0, memreq_valid}, 32'd1);
    chk("t6_next_addr", memreq_addr, 32'h600);
    tick;
    memreq_ready = 1'b0; memresp_valid = 1'b1; memresp_rdata = 32'hcafef00d;
    #3;
    chk("t6_next_dresp", {31'b0, dresp_valid}, 32'd1);
    chk("t6_next_rdata", dresp_rdata, 32'hcafef00d);
    tick;
    memresp_valid = 1'b0;
    #3;
    chk("t6_end_dresp", {31'b0, dresp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
